mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory stage of the five-stage pipeline. It sits between the execute-to-memory pipeline register and the memory-to-writeback register.
- Issues data-cache read/write requests for the instruction currently in MEM and holds the pipeline until the cache answers.
- Registers results into the MEM/WB register and exposes a forwarding value for the hazard/forward unit.

Parameters:
- MAX_WAIT, 255, cycles a request may wait for dhit before mem_err is raised (8-bit wait counter).

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- en  in  1  pipeline advance from hazard unit
- flush  in  1  insert bubble into MEM/WB on advance
- in_dmemREN  in  1  load in MEM
- in_dmemWEN  in  1  store in MEM
- in_halt  in  1  halt in MEM
- in_alu_result  in  32  address / ALU value
- in_wsel  in  5  destination register
- in_wdat_source  in  2  0=ALU, 1=MEM, 2=NPC, 3=ALU
- in_instr_npc  in  32  PC+4 of instruction
- in_dmemstore  in  32  store data
- dhit  in  1  cache completes request this cycle
- dmemload  in  32  load data, valid with dhit
- dmemREN  out  1  cache read request
- dmemWEN  out  1  cache write request
- dmemaddr  out  32  request address
- dmemstore  out  32  request write data
- mem_stall  out  1  MEM cannot advance
- fwd_valid  out  1  fwd_data usable this cycle
- fwd_data  out  32  value the MEM instruction will write back
- out_halt  out  1  MEM/WB halt
- out_wsel  out  5  MEM/WB destination
- out_wdat_source  out  2  MEM/WB source select
- out_alu_result  out  32  MEM/WB ALU value
- out_dmemload  out  32  MEM/WB load data
- out_instr_npc  out  32  MEM/WB PC+4
- mem_err  out  1  sticky: a request exceeded MAX_WAIT

Behaviour:
- Reset (async, nRST low):
  - State IDLE, wait counter 0, load-hold register 0, halted flag 0.
  - All out_* = 0, mem_err = 0.
  - dmemREN = dmemWEN = 0, mem_stall = 0.
  - An in-flight request is dropped immediately with no completion.
- State machine: IDLE, ACCESS, DONE.
  - req = (in_dmemREN | in_dmemWEN) & !halted.
  - IDLE: if req, then dmemREN/dmemWEN = in_* in the same cycle (combinational).
    - If dhit in that same cycle, go to DONE (zero-wait hit).
    - If no dhit, go to ACCESS.
  - ACCESS: request held, dmemaddr = in_alu_result, dmemstore = in_dmemstore; go to DONE on dhit.
  - DONE: request deasserted; return to IDLE on the cycle the register advances.
  - On every dhit, load-hold register <= dmemload.
- mem_stall = req & (state != DONE) & !dhit.
  - A zero-wait hit causes no stall.
  - Each extra wait cycle adds exactly one stall cycle.
- Advance condition: adv = en & !mem_stall. en asserted while stalled is ignored; no register update.
- MEM/WB register, on adv:
  - flush=1: all out_* <= 0 (bubble).
  - flush=0: pass the in_* fields through.
  - out_dmemload <= dmemload if dhit this cycle, else load-hold register.
- DONE exists so that when the hazard unit holds en low after completion, the access is not re-issued (no duplicate store).
- Flush does not abort an outstanding cache request. The access completes first, then the bubble is taken on advance.
- Halt:
  - When a non-flushed in_halt advances, halted <= 1 and out_halt <= 1.
  - Both are sticky until reset; no further cache requests are issued.
- Forwarding:
  - fwd_data = in_instr_npc when wdat_source=2.
  - fwd_data = load data (dmemload if dhit, else hold) when 1.
  - fwd_data = in_alu_result otherwise.
  - fwd_valid = 0 only when wdat_source=1 and the load has not yet completed (IDLE/ACCESS without dhit).
- Watchdog:
  - Counter increments each ACCESS cycle without dhit, saturating at MAX_WAIT.
  - Reaching MAX_WAIT sets mem_err (sticky).
  - Counter clears on dhit.
  - Stall behaviour is unchanged by mem_err.

Test Plan:
- Load, addr 0x100, dhit on 3rd cycle, dmemload 0xDEADBEEF, en=1 → mem_stall high 2 cycles, dmemREN high 3 cycles; next cycle out_dmemload=0xDEADBEEF, out_wsel copied.
- Store, addr 0x200, data 0x1234 with zero-wait dhit → no stall, dmemWEN high 1 cycle, dmemstore=0x1234.
- Store completes but en held low 3 cycles → dmemWEN never reasserts in DONE; register advances once en=1.
- flush=1 during a pending load → stall continues until dhit, then out_* all 0.
- halt advances, then a load follows → out_halt=1 sticky, dmemREN stays 0; nRST low mid-ACCESS → all outputs 0 immediately.
- dhit withheld 256 cycles with MAX_WAIT=255 → mem_err rises after 255 wait cycles and stays set after a late dhit.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: issues data-cache requests for the instruction in MEM, stalls until
// dhit, then loads the MEM/WB register and presents a forwarding value.
module mem_stage #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        en,
  input  logic        flush,
  input  logic        in_dmemREN,
  input  logic        in_dmemWEN,
  input  logic        in_halt,
  input  logic [31:0] in_alu_result,
  input  logic [4:0]  in_wsel,
  input  logic [1:0]  in_wdat_source,
  input  logic [31:0] in_instr_npc,
  input  logic [31:0] in_dmemstore,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        fwd_valid,
  output logic [31:0] fwd_data,
  output logic        out_halt,
  output logic [4:0]  out_wsel,
  output logic [1:0]  out_wdat_source,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_dmemload,
  output logic [31:0] out_instr_npc,
  output logic        mem_err
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [7:0] MAX_W  = 8'(MAX_WAIT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] hold_q, hold_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;
  logic        out_halt_q, out_halt_d;
  logic [4:0]  out_wsel_q, out_wsel_d;
  logic [1:0]  out_src_q, out_src_d;
  logic [31:0] out_alu_q, out_alu_d;
  logic [31:0] out_load_q, out_load_d;
  logic [31:0] out_npc_q, out_npc_d;

  logic        req, pending, adv;
  logic [31:0] load_data;

  // Handshake: a request stays asserted from IDLE through ACCESS until dhit; the
  // stage advances only on en & !mem_stall, and DONE blocks re-issue while en is low.
  assign req       = (in_dmemREN | in_dmemWEN) & ~halted_q & nRST;
  assign pending   = req & (state_q != DONE);
  assign mem_stall = pending & ~dhit;
  assign adv       = en & ~mem_stall;
  assign load_data = dhit ? dmemload : hold_q;

  assign dmemREN   = pending & in_dmemREN;
  assign dmemWEN   = pending & in_dmemWEN;
  assign dmemaddr  = in_alu_result;
  assign dmemstore = in_dmemstore;

  always_comb begin
    fwd_valid = 1'b1;
    fwd_data  = in_alu_result;
    if (in_wdat_source == 2'd2) begin
      fwd_data = in_instr_npc;
    end else if (in_wdat_source == 2'd1) begin
      fwd_data  = load_data;
      fwd_valid = ~(state_q != DONE && ~dhit);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    hold_d     = hold_q;
    halted_d   = halted_q;
    err_d      = err_q;
    out_halt_d = out_halt_q;
    out_wsel_d = out_wsel_q;
    out_src_d  = out_src_q;
    out_alu_d  = out_alu_q;
    out_load_d = out_load_q;
    out_npc_d  = out_npc_q;

    case (state_q)
      IDLE, ACCESS: begin
        if (req && dhit)  state_d = adv ? IDLE : DONE;
        else if (req)     state_d = ACCESS;
        else              state_d = IDLE;
      end
      DONE:    if (adv) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (dhit) begin
      wait_d = 8'd0;
      hold_d = dmemload;
    end else if (state_q == ACCESS && wait_q != MAX_W) begin
      wait_d = wait_q + 8'd1;
    end
    if (wait_d == MAX_W) err_d = 1'b1;

    if (adv) begin
      if (flush) begin
        out_wsel_d = 5'd0;
        out_src_d  = 2'd0;
        out_alu_d  = 32'd0;
        out_load_d = 32'd0;
        out_npc_d  = 32'd0;
      end else begin
        out_halt_d = out_halt_q | in_halt;
        halted_d   = halted_q | in_halt;
        out_wsel_d = in_wsel;
        out_src_d  = in_wdat_source;
        out_alu_d  = in_alu_result;
        out_load_d = load_data;
        out_npc_d  = in_instr_npc;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      wait_q     <= 8'd0;
      hold_q     <= 32'd0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      out_halt_q <= 1'b0;
      out_wsel_q <= 5'd0;
      out_src_q  <= 2'd0;
      out_alu_q  <= 32'd0;
      out_load_q <= 32'd0;
      out_npc_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      hold_q     <= hold_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
      out_halt_q <= out_halt_d;
      out_wsel_q <= out_wsel_d;
      out_src_q  <= out_src_d;
      out_alu_q  <= out_alu_d;
      out_load_q <= out_load_d;
      out_npc_q  <= out_npc_d;
    end
  end

  assign out_halt        = out_halt_q;
  assign out_wsel        = out_wsel_q;
  assign out_wdat_source = out_src_q;
  assign out_alu_result  = out_alu_q;
  assign out_dmemload    = out_load_q;
  assign out_instr_npc   = out_npc_q;
  assign mem_err         = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed instructions push expected MEM/WB contents into a
// queue; a negedge monitor pops and compares after every register advance.
module tb_mem_stage;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        en = 1'b0, flush = 1'b0;
  logic        in_dmemREN = 1'b0, in_dmemWEN = 1'b0, in_halt = 1'b0;
  logic [31:0] in_alu_result = '0, in_instr_npc = '0, in_dmemstore = '0;
  logic [4:0]  in_wsel = '0;
  logic [1:0]  in_wdat_source = '0;
  logic        dhit = 1'b0;
  logic [31:0] dmemload = '0;
  logic        dmemREN, dmemWEN, mem_stall, fwd_valid, out_halt, mem_err;
  logic [31:0] dmemaddr, dmemstore, fwd_data, out_alu_result, out_dmemload, out_instr_npc;
  logic [4:0]  out_wsel;
  logic [1:0]  out_wdat_source;

  mem_stage #(.MAX_WAIT(255)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_dmemREN(in_dmemREN), .in_dmemWEN(in_dmemWEN), .in_halt(in_halt),
    .in_alu_result(in_alu_result), .in_wsel(in_wsel), .in_wdat_source(in_wdat_source),
    .in_instr_npc(in_instr_npc), .in_dmemstore(in_dmemstore),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
    .out_halt(out_halt), .out_wsel(out_wsel), .out_wdat_source(out_wdat_source),
    .out_alu_result(out_alu_result), .out_dmemload(out_dmemload),
    .out_instr_npc(out_instr_npc), .mem_err(mem_err)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  logic [103:0] exp_q[$];
  logic [103:0] mon_exp;
  int           n_checks = 0;
  int           n_fail = 0;
  logic         pend = 1'b0;
  logic         halted_m = 1'b0, err_m = 1'b0;
  logic [31:0]  hold_m = '0;
  int           wd_m = 0;

  function automatic logic [103:0] memwb();
    return {out_halt, out_wsel, out_wdat_source, out_alu_result, out_dmemload, out_instr_npc};
  endfunction

  task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_advance: got %h expected none", memwb());
      end else begin
        mon_exp = exp_q.pop_front();
        check("memwb_reg", memwb(), mon_exp);
      end
    end
    pend = nRST && en && !mem_stall;
  end

  // driver: one instruction, dhit after 'waits' cycles, en held low 'hold' cycles after that
  task automatic issue(input logic ren, input logic wen, input logic halt, input logic flsh,
                       input logic [31:0] alu, input logic [4:0] wsel, input logic [1:0] src,
                       input logic [31:0] npc, input logic [31:0] store, input logic [31:0] load,
                       input int waits, input int hold);
    logic        req;
    int          last;
    logic [31:0] fexp;
    req = (ren | wen) & !halted_m;
    if (flsh) exp_q.push_back({halted_m, 103'd0});
    else exp_q.push_back({halted_m | halt, wsel, src, alu, (req ? load : hold_m), npc});
    in_dmemREN = ren; in_dmemWEN = wen; in_halt = halt; flush = flsh;
    in_alu_result = alu; in_wsel = wsel; in_wdat_source = src;
    in_instr_npc = npc; in_dmemstore = store;
    last = (req ? waits : 0) + hold;
    for (int c = 0; c <= last; c++) begin
      en = (hold == 0) || (c >= last);
      dhit = req && (c == waits);
      dmemload = dhit ? load : 32'hBAD0_BAD0;
      @(negedge CLK);
      check("mem_stall", mem_stall, req && c < waits);
      check("dmemREN", dmemREN, ren && req && c <= waits);
      check("dmemWEN", dmemWEN, wen && req && c <= waits);
      check("mem_err", mem_err, err_m);
      if (req && c <= waits) begin
        check("dmemaddr", dmemaddr, alu);
        check("dmemstore", dmemstore, store);
      end
      if (req) begin
        if (src == 2'd1 && c < waits) begin
          check("fwd_valid_pending", fwd_valid, 1'b0);
        end else begin
          fexp = (src == 2'd2) ? npc : (src == 2'd1) ? load : alu;
          check("fwd_valid", fwd_valid, 1'b1);
          check("fwd_data", fwd_data, fexp);
        end
      end
      @(posedge CLK);
      if (req && c >= 1 && c < waits && wd_m < 255) wd_m++;
      if (wd_m == 255) err_m = 1'b1;
      if (dhit) begin
        wd_m = 0;
        hold_m = load;
      end
      #1;
    end
    if (!flsh && halt) halted_m = 1'b1;
    en = 1'b0; dhit = 1'b0; flush = 1'b0;
    in_dmemREN = 1'b0; in_dmemWEN = 1'b0; in_halt = 1'b0;
    dmemload = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_memwb"}, memwb(), 104'd0);
    check({tag, "_dmemREN"}, dmemREN, 1'b0);
    check({tag, "_dmemWEN"}, dmemWEN, 1'b0);
    check({tag, "_mem_stall"}, mem_stall, 1'b0);
    check({tag, "_mem_err"}, mem_err, 1'b0);
  endtask

  initial begin
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // load with two wait cycles, en high throughout
    issue(1, 0, 0, 0, 32'h100, 5'd3, 2'd1, 32'h1004, 32'h0, 32'hDEADBEEF, 2, 0);
    // zero-wait store
    issue(0, 1, 0, 0, 32'h200, 5'd0, 2'd0, 32'h2004, 32'h1234, 32'h0, 0, 0);
    // ALU op forwarding npc
    issue(0, 0, 0, 0, 32'h55, 5'd7, 2'd2, 32'h3008, 32'h0, 32'h0, 0, 0);
    // store completes, en held low three more cycles
    issue(0, 1, 0, 0, 32'h204, 5'd0, 2'd0, 32'h300C, 32'hCAFE, 32'h11, 1, 3);
    // flush during a pending load
    issue(1, 0, 0, 1, 32'h104, 5'd9, 2'd1, 32'h3010, 32'h0, 32'h87654321, 3, 0);
    // zero-wait load with wdat_source 3
    issue(1, 0, 0, 0, 32'h108, 5'd10, 2'd3, 32'h3014, 32'h0, 32'hA5A5A5A5, 0, 0);
    // watchdog: dhit withheld 256 cycles
    issue(1, 0, 0, 0, 32'h10C, 5'd11, 2'd1, 32'h3018, 32'h0, 32'h77, 256, 0);
    check("mem_err_sticky", mem_err, 1'b1);

    // reset in the middle of an ACCESS
    in_dmemREN = 1'b1; in_alu_result = 32'h300; in_wdat_source = 2'd1; en = 1'b1;
    repeat (3) @(negedge CLK);
    check("access_stall", mem_stall, 1'b1);
    check("access_ren", dmemREN, 1'b1);
    #2 en = 1'b0; nRST = 1'b0;
    #1 check_reset_outputs("mid_access");
    in_dmemREN = 1'b0; in_alu_result = 32'h0; in_wdat_source = 2'd0;
    halted_m = 1'b0; err_m = 1'b0; hold_m = 32'h0; wd_m = 0;
    @(posedge CLK);
    #1 nRST = 1'b1;

    // halt, then a load and a store that must not issue
    issue(0, 0, 1, 0, 32'h0, 5'd0, 2'd0, 32'h4004, 32'h0, 32'h0, 0, 0);
    issue(1, 0, 0, 0, 32'h110, 5'd12, 2'd1, 32'h4008, 32'h0, 32'h99, 2, 0);
    issue(0, 1, 0, 0, 32'h210, 5'd0, 2'd0, 32'h400C, 32'h5678, 32'h0, 1, 0);
    check("halt_sticky", out_halt, 1'b1);

    repeat (3) @(negedge CLK);
    check("queue_drained", 104'(exp_q.size()), 104'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
